// File: rtl/palindrome_generator.sv
// rtl/palindrome_generator.sv - serial MSB-first palindrome frame transmitter, seed plus mirror
// Optional macro PALGEN_BACK_TO_BACK_EN allows a new seed on the last bit for gapless frames.
module palindrome_generator #(
  parameter  int BITS   = 4,
  localparam int SEED_W = (BITS + 1) / 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEED_W-1:0] seed,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic              advance,
  output logic              out,
  output logic              out_valid,
  output logic              frame_start,
  output logic              frame_end
);

  localparam int            CW       = $clog2(BITS + 1);
  localparam logic [CW-1:0] C_LAST   = CW'(BITS - 1);
  localparam logic [CW-1:0] C_SEED_W = CW'(SEED_W);
  localparam logic [CW-1:0] C_MIR    = CW'(BITS - SEED_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_REV  = 2'd2
  } state_t;

  state_t            r_state, w_state_n;
  logic [CW-1:0]     r_cnt, w_cnt_n, w_cnt_inc, w_idx;
  logic [SEED_W-1:0] r_seed, w_seed_n, w_shift;
  logic              r_out, w_out_n;
  logic              r_out_valid, w_valid_n;
  logic              r_fs, w_fs_n;
  logic              r_fe, w_fe_n;
  logic              w_last, w_load_ready, w_accept, w_bit;

  assign w_last = r_out_valid & (r_cnt == C_LAST);

`ifdef PALGEN_BACK_TO_BACK_EN
  assign w_load_ready = (r_state == S_IDLE) | (w_last & advance);
`else
  assign w_load_ready = (r_state == S_IDLE);
`endif

  assign w_accept  = load_valid & w_load_ready;
  assign w_cnt_inc = r_cnt + CW'(1);

  // Frame position k maps to seed index SEED_W-1-k on the way out and k-(BITS-SEED_W) on the way back.
  assign w_idx   = (w_cnt_inc < C_SEED_W) ? (C_SEED_W - CW'(1) - w_cnt_inc)
                                          : (w_cnt_inc - C_MIR);
  assign w_shift = r_seed >> w_idx;
  assign w_bit   = w_shift[0];

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_seed_n  = r_seed;
    w_out_n   = r_out;
    w_valid_n = r_out_valid;
    w_fs_n    = r_fs;
    w_fe_n    = r_fe;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_n = S_FWD;
          w_cnt_n   = '0;
          w_seed_n  = seed;
          w_out_n   = seed[SEED_W-1];
          w_valid_n = 1'b1;
          w_fs_n    = 1'b1;
          w_fe_n    = 1'b0;
        end
      end
      S_FWD, S_REV: begin
        if (advance) begin
          if (r_cnt == C_LAST) begin
            if (w_accept) begin
              w_state_n = S_FWD;
              w_cnt_n   = '0;
              w_seed_n  = seed;
              w_out_n   = seed[SEED_W-1];
              w_valid_n = 1'b1;
              w_fs_n    = 1'b1;
              w_fe_n    = 1'b0;
            end else begin
              w_state_n = S_IDLE;
              w_cnt_n   = '0;
              w_out_n   = 1'b0;
              w_valid_n = 1'b0;
              w_fs_n    = 1'b0;
              w_fe_n    = 1'b0;
            end
          end else begin
            w_state_n = (w_cnt_inc >= C_SEED_W) ? S_REV : S_FWD;
            w_cnt_n   = w_cnt_inc;
            w_out_n   = w_bit;
            w_fs_n    = 1'b0;
            w_fe_n    = (w_cnt_inc == C_LAST);
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
        w_out_n   = 1'b0;
        w_valid_n = 1'b0;
        w_fs_n    = 1'b0;
        w_fe_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_seed      <= '0;
      r_out       <= 1'b0;
      r_out_valid <= 1'b0;
      r_fs        <= 1'b0;
      r_fe        <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_seed      <= w_seed_n;
      r_out       <= w_out_n;
      r_out_valid <= w_valid_n;
      r_fs        <= w_fs_n;
      r_fe        <= w_fe_n;
    end
  end

  assign load_ready  = w_load_ready;
  assign out         = r_out;
  assign out_valid   = r_out_valid;
  assign frame_start = r_fs;
  assign frame_end   = r_fe;

endmodule

// File: tb/tb_palindrome_generator.sv
// tb/tb_palindrome_generator.sv - scoreboard bench for palindrome_generator at BITS=4, 5 and 6
module tb_palindrome_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, lv4, lr4, adv4, o4, ov4, fs4, fe4;
  logic [1:0] seed4;
  logic       rst5, lv5, lr5, adv5, o5, ov5, fs5, fe5;
  logic [2:0] seed5;
  logic       rst6, lv6, lr6, adv6, o6, ov6, fs6, fe6;
  logic [2:0] seed6;

  palindrome_generator #(.BITS(4)) u_dut4 (
    .clk(clk), .reset(rst4), .seed(seed4), .load_valid(lv4), .load_ready(lr4),
    .advance(adv4), .out(o4), .out_valid(ov4), .frame_start(fs4), .frame_end(fe4));
  palindrome_generator #(.BITS(5)) u_dut5 (
    .clk(clk), .reset(rst5), .seed(seed5), .load_valid(lv5), .load_ready(lr5),
    .advance(adv5), .out(o5), .out_valid(ov5), .frame_start(fs5), .frame_end(fe5));
  palindrome_generator #(.BITS(6)) u_dut6 (
    .clk(clk), .reset(rst6), .seed(seed6), .load_valid(lv6), .load_ready(lr6),
    .advance(adv6), .out(o6), .out_valid(ov6), .frame_start(fs6), .frame_end(fe6));

  // Scoreboard entries are {bit, frame_start, frame_end}.
  logic [2:0] sb4[$], sb5[$], sb6[$];
  int n_pass = 0, n_total = 0;
  int v4cnt = 0, gap4 = 0, pal_frames = 0;
  logic [3:0] det4 = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_total++;
    $display("FAIL %s: got timeout/unexpected expected event", nm);
  endtask

  always @(negedge clk) begin
    if (rst4) begin
      if (ov4) begin
        v4cnt++;
        if (sb4.size() == 0) fail_now("dut4_unexpected_bit");
        else begin
          chk("dut4_bit", {29'd0, o4, fs4, fe4}, {29'd0, sb4[0]});
          if (adv4) void'(sb4.pop_front());
        end
      end else if (sb4.size() > 0) gap4++;
    end
  end

  always @(negedge clk) begin : det_model
    logic [3:0] nd, rv;
    if (rst4 && ov4 && adv4) begin
      nd = {det4[2:0], o4};
      det4 <= nd;
      if (fe4) begin
        for (int i = 0; i < 4; i++) rv[i] = nd[3-i];
        chk("loopback_palindrome", {28'd0, nd}, {28'd0, rv});
        pal_frames++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst5 && ov5) begin
      if (sb5.size() == 0) fail_now("dut5_unexpected_bit");
      else begin
        chk("dut5_bit", {29'd0, o5, fs5, fe5}, {29'd0, sb5[0]});
        if (adv5) void'(sb5.pop_front());
      end
      if (!(fe5 && adv5)) chk("dut5_ready_low", {31'd0, lr5}, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (rst6 && ov6) begin
      if (sb6.size() == 0) fail_now("dut6_unexpected_bit");
      else begin
        chk("dut6_bit", {29'd0, o6, fs6, fe6}, {29'd0, sb6[0]});
        if (adv6) void'(sb6.pop_front());
      end
    end
  end

  task automatic send4(input logic [1:0] s, input logic [3:0] bits);
    int n = 0;
    while (!lr4 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) fail_now("send4_ready_timeout");
    seed4 = s; lv4 = 1'b1;
    for (int k = 0; k < 4; k++) sb4.push_back({bits[3-k], k == 0, k == 3});
    @(posedge clk); #1;
    lv4 = 1'b0; seed4 = ~s;
  endtask

  task automatic send5(input logic [2:0] s, input logic [4:0] bits);
    int n = 0;
    while (!lr5 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) fail_now("send5_ready_timeout");
    seed5 = s; lv5 = 1'b1;
    for (int k = 0; k < 5; k++) sb5.push_back({bits[4-k], k == 0, k == 4});
    @(posedge clk); #1;
    lv5 = 1'b0; seed5 = ~s;
  endtask

  task automatic send6(input logic [2:0] s, input logic [5:0] bits);
    int n = 0;
    while (!lr6 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) fail_now("send6_ready_timeout");
    seed6 = s; lv6 = 1'b1;
    for (int k = 0; k < 6; k++) sb6.push_back({bits[5-k], k == 0, k == 5});
    @(posedge clk); #1;
    lv6 = 1'b0; seed6 = ~s;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb4.size() > 0 || sb5.size() > 0 || sb6.size() > 0 || ov4 || ov5 || ov6) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) fail_now("wait_idle_timeout");
  endtask

  initial begin
    logic [1:0] s;
    rst4 = 1'b0; rst5 = 1'b0; rst6 = 1'b0;
    lv4 = 1'b0; lv5 = 1'b0; lv6 = 1'b0;
    adv4 = 1'b1; adv5 = 1'b1; adv6 = 1'b1;
    seed4 = '0; seed5 = '0; seed6 = '0;
    #1;
    chk("rst_dut4", {27'd0, o4, ov4, fs4, fe4, lr4}, 32'h1);
    chk("rst_dut5", {27'd0, o5, ov5, fs5, fe5, lr5}, 32'h1);
    chk("rst_dut6", {27'd0, o6, ov6, fs6, fe6, lr6}, 32'h1);
    @(posedge clk); #1;
    rst4 = 1'b1; rst5 = 1'b1; rst6 = 1'b1;
    @(posedge clk); #1;

    send4(2'b10, 4'b1001);
    wait_idle();
    chk("dut4_idle_after_frame", {31'd0, ov4}, 32'd0);

    send5(3'b110, 5'b11011);
    wait_idle();

    v4cnt = 0;
    send4(2'b01, 4'b0110);
    @(posedge clk); #1;
    adv4 = 1'b0;
    repeat (3) @(posedge clk);
    #1 adv4 = 1'b1;
    wait_idle();
    chk("stall_valid_cycles", v4cnt, 32'd7);

    send6(3'b011, 6'b011110);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst6 = 1'b0;
    #1;
    chk("midframe_rst_valid", {31'd0, ov6}, 32'd0);
    chk("midframe_rst_ready", {31'd0, lr6}, 32'd1);
    chk("midframe_rst_flags", {29'd0, o6, fs6, fe6}, 32'd0);
    sb6.delete();
    @(posedge clk); #1 rst6 = 1'b1;
    send6(3'b101, 6'b101101);
    wait_idle();

    send4(2'b11, 4'b1111);
    gap4 = 0;
    send4(2'b10, 4'b1001);
    wait_idle();
`ifdef PALGEN_BACK_TO_BACK_EN
    chk("b2b_gap_cycles", gap4, 32'd0);
`else
    chk("b2b_gap_cycles", gap4, 32'd1);
`endif

    pal_frames = 0;
    for (int i = 0; i < 16; i++) begin
      s = 2'($urandom_range(0, 3));
      send4(s, {s, s[0], s[1]});
    end
    wait_idle();
    chk("loopback_frames", pal_frames, 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/palindrome_generator.md
Name: palindrome_generator

Overview:
Serial palindrome transmitter: accepts a seed word over a valid/ready handshake and emits, one bit per clock, a BITS-long palindromic frame. The frame is built from the seed followed by its mirror. Its serial output feeds the team's serial palindrome detector, both as a stimulus source and for link loop-back checks. Frames are MSB-first, so a detector shifting bits into its LSB holds the frame with the first bit at its top position.

Parameters:
BITS, 4, total frame length in bits; legal range 2..64; odd values supported.
SEED_W, (BITS+1)/2, derived localparam, not user-set: seed width (ceil of BITS/2).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
seed  input  SEED_W  first half of frame (includes the middle bit when BITS is odd).
load_valid  input  1  seed is valid this cycle.
load_ready  output  1  block can accept a seed this cycle.
advance  input  1  downstream accepts the current bit; 0 = stall and hold the output.
out  output  1  serial frame bit.
out_valid  output  1  out carries a frame bit.
frame_start  output  1  high with the first bit of each frame.
frame_end  output  1  high with the last bit of each frame.

Behaviour:
- Reset (reset=0, asynchronous): out=0, out_valid=0, frame_start=0, frame_end=0, load_ready=1, FSM=IDLE, bit counter=0, seed register=0. Takes effect immediately, with no clock needed.
- Reset mid-frame aborts the frame: no partial completion, and out_valid drops asynchronously.
- Accept condition: load_valid & load_ready sampled at a rising edge. The seed is captured into an internal register; later changes on seed are ignored until the next accept.
- All outputs are registered. The first bit appears on out/out_valid the cycle after accept, so latency is 1 clk.
- FSM states:
  - IDLE: load_ready=1, out_valid=0. Accept -> FWD, counter=0.
  - FWD: emit seed_reg[SEED_W-1] down to seed_reg[0], one bit per advanced cycle.
    - After seed_reg[0]: if BITS is even -> REV starting at seed_reg[0]; if BITS is odd -> REV starting at seed_reg[1], so the middle bit is not repeated.
  - REV: emit ascending indices up to seed_reg[SEED_W-1].
    - After the last bit: -> IDLE, or directly to FWD per the optional feature.
- Mirror rule: frame bit k equals frame bit BITS-1-k for every k, so every frame is a palindrome by construction.
- Total frame length is exactly BITS advanced cycles.
- Stall: when advance=0 while out_valid=1, out, out_valid, frame_start, frame_end, the counter and the FSM all hold. advance has no effect in IDLE.
- frame_start is high only while the frame's first bit is presented, including stalled cycles on that bit. frame_end behaves the same for the last bit.
- load_valid while load_ready=0 is ignored: no capture and no error.
- Counter width is $clog2(BITS+1). It never exceeds BITS-1 and has no wrap-around inside a frame.

Optional Feature:
Macro PALGEN_BACK_TO_BACK_EN.
- Defined: load_ready is also 1 during the cycle that presents the last bit with advance=1. An accept in that cycle starts the next frame on the following cycle (FWD, frame_start=1), giving a continuous stream with no idle bit.
- Undefined: load_ready=1 only in IDLE. Consecutive frames are separated by at least one cycle with out_valid=0.

Test Plan:
- BITS=4, reset released, seed=2'b10 accepted, advance=1 -> out 1,0,0,1 over cycles 1..4; frame_start on cycle 1, frame_end on cycle 4; out_valid=0 on cycle 5.
- BITS=5, seed=3'b110 -> out 1,1,0,1,1; the middle bit (0) appears exactly once; load_ready=0 during cycles 1..5.
- BITS=4, seed=2'b01, advance held low during bit 2 for 3 cycles -> out holds 1 for 3 extra cycles; sequence is still 0,1,1,0; total out_valid-high cycles = 7.
- BITS=6, reset driven to 0 during bit 3 -> out_valid=0 and load_ready=1 immediately; after release, a new seed 3'b101 produces a full frame 1,0,1,1,0,1.
- Two seeds 2'b11 then 2'b10 presented continuously:
  - With PALGEN_BACK_TO_BACK_EN: 1,1,1,1,1,0,0,1 with no gap.
  - Without the macro: one out_valid=0 cycle between the two frames.
- Loop-back: generator out drives the palindrome detector input (BITS=4), with 16 random seeds -> the detector flags a palindrome at every frame_end.
